// File: rtl/eth_frame_sender_pkg.sv
// Shared types and constants for the frame-template transmitter.
package eth_frame_sender_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE} state_t;

    localparam int unsigned C_MIN_FRAME_SIZE = 60;

    // Frame length actually put on the wire: short frames are padded, long ones clipped.
    function automatic logic [15:0] eff_len(input logic [15:0] flen, input int unsigned max_size);
        int unsigned len;
        len = 32'(flen);
        if (len < C_MIN_FRAME_SIZE) len = C_MIN_FRAME_SIZE;
        if (len > max_size) len = max_size;
        return 16'(len);
    endfunction

endpackage

// File: rtl/eth_frame_sender_if.sv
// Byte-wide AXI4-Stream link from the sender to the TEMAC TX port.
interface eth_frame_sender_if;
    logic [7:0] tdata;
    logic       tuser;
    logic       tlast;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/eth_frame_sender_ram.sv
// Template store: port A is the register-bus side, port B feeds the TX path.
module eth_frame_sender_ram #(
    parameter int unsigned C_DEPTH = 512,
    parameter int unsigned C_AW    = 9
) (
    input  logic            clk,
    input  logic            a_en,
    input  logic            a_we,
    input  logic [C_AW-1:0] a_addr,
    input  logic [31:0]     a_wdata,
    output logic [31:0]     a_rdata,
    input  logic [C_AW-1:0] b_addr,
    output logic [31:0]     b_rdata
);

    logic [31:0] mem [C_DEPTH];

    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) mem[a_addr] <= a_wdata;
            a_rdata <= mem[a_addr];
        end
    end

    always_ff @(posedge clk) begin
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/eth_frame_sender.sv
// Replays a RAM-held frame template onto the TEMAC TX stream a programmed number of times.
module eth_frame_sender
    import eth_frame_sender_pkg::*;
#(
    parameter int unsigned C_AXI_WIDTH      = 32,
    parameter int unsigned C_MAX_FRAME_SIZE = 2048,
    localparam int unsigned AW = $clog2(C_MAX_FRAME_SIZE / 4)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   srst,
    input  logic                   mem_req,
    input  logic [AW-1:0]          mem_addr,
    input  logic                   mem_wenable,
    input  logic [C_AXI_WIDTH-1:0] mem_wdata,
    output logic [C_AXI_WIDTH-1:0] mem_rdata,
    output logic                   mem_ack,
    input  logic                   start,
    input  logic                   stop,
    input  logic [15:0]            frame_len,
    input  logic [31:0]            frame_count,
    input  logic [15:0]            gap,
    output logic                   busy,
    output logic [63:0]            frames_sent,
    eth_frame_sender_if.master     m_axis
);

    logic        rst;
    logic        mem_ack_q;
    logic        mem_en;
    logic [31:0] a_rdata;
    logic [31:0] b_rdata;

    state_t      state;
    logic        busy_q, stop_pend, load_ph;
    logic [15:0] flen_r, len_r, gap_r, gap_cnt, rd_idx;
    logic [31:0] count_r;
    logic [63:0] frames_q;

    logic        rd_pend, rd_pad, rd_last;
    logic [1:0]  rd_sel;
    logic [8:0]  pbuf [2];
    logic [1:0]  pcnt, cnt_next;
    logic        tvalid_q, tlast_q;
    logic [7:0]  tdata_q, ram_byte;
    logic [8:0]  ram_entry;
    logic        active, xfer, out_load, buf_pop, buf_push, wr_pos, issue;

    assign rst    = !rst_n || srst;
    assign mem_en = mem_req && !mem_ack_q && !rst;

    eth_frame_sender_ram #(
        .C_DEPTH (C_MAX_FRAME_SIZE / 4),
        .C_AW    (AW)
    ) u_ram (
        .clk     (clk),
        .a_en    (mem_en),
        .a_we    (mem_wenable),
        .a_addr  (mem_addr),
        .a_wdata (mem_wdata),
        .a_rdata (a_rdata),
        .b_addr  (rd_idx[AW+1:2]),
        .b_rdata (b_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) mem_ack_q <= 1'b0;
        else     mem_ack_q <= mem_req && !mem_ack_q;
    end

    assign mem_ack   = mem_ack_q;
    assign mem_rdata = mem_ack_q ? a_rdata : '0;

    // Output register is fed from the 2-entry buffer, or straight from RAM when the buffer is empty.
    assign ram_byte  = rd_pad ? 8'h00 : b_rdata[{rd_sel, 3'b000} +: 8];
    assign ram_entry = {rd_last, ram_byte};
    assign active    = (state == LOAD) || (state == SEND);
    assign xfer      = tvalid_q && m_axis.tready;
    assign out_load  = active && (!tvalid_q || m_axis.tready) && ((pcnt != 2'd0) || rd_pend);
    assign buf_pop   = out_load && (pcnt != 2'd0);
    assign buf_push  = rd_pend && !(out_load && (pcnt == 2'd0));
    assign wr_pos    = (pcnt == 2'd2) || ((pcnt == 2'd1) && !buf_pop);
    assign cnt_next  = pcnt + {1'b0, buf_push} - {1'b0, buf_pop};
    assign issue     = active && (rd_idx < len_r) && (cnt_next != 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            stop_pend <= 1'b0;
            load_ph   <= 1'b0;
            flen_r    <= '0;
            len_r     <= '0;
            gap_r     <= '0;
            gap_cnt   <= '0;
            count_r   <= '0;
            frames_q  <= '0;
            rd_idx    <= '0;
            rd_pend   <= 1'b0;
            rd_pad    <= 1'b0;
            rd_last   <= 1'b0;
            rd_sel    <= '0;
            pcnt      <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
        end else begin
            rd_pend <= issue;
            if (issue) begin
                rd_idx  <= rd_idx + 16'd1;
                rd_sel  <= rd_idx[1:0];
                rd_pad  <= rd_idx >= flen_r;
                rd_last <= rd_idx == (len_r - 16'd1);
            end
            if (buf_pop)  pbuf[0] <= pbuf[1];
            if (buf_push) pbuf[wr_pos] <= ram_entry;
            pcnt <= cnt_next;

            if (out_load) begin
                {tlast_q, tdata_q} <= (pcnt != 2'd0) ? pbuf[0] : ram_entry;
                tvalid_q           <= 1'b1;
            end else if (xfer) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end

            if (stop && state != IDLE) stop_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        busy_q    <= 1'b1;
                        stop_pend <= stop;
                        flen_r    <= frame_len;
                        len_r     <= eff_len(frame_len, C_MAX_FRAME_SIZE);
                        count_r   <= frame_count;
                        gap_r     <= gap;
                        frames_q  <= '0;
                        rd_idx    <= '0;
                        load_ph   <= 1'b0;
                    end
                end
                LOAD: begin
                    load_ph <= 1'b1;
                    if (load_ph) state <= SEND;
                end
                SEND: begin
                    if (xfer && tlast_q) begin
                        frames_q <= frames_q + 64'd1;
                        if (stop_pend || stop ||
                            (count_r != '0 && (frames_q + 64'd1) == {32'd0, count_r})) begin
                            state <= DONE;
                        end else if (gap_r != '0) begin
                            state   <= GAP;
                            gap_cnt <= gap_r - 16'd1;
                        end else begin
                            state   <= LOAD;
                            rd_idx  <= '0;
                            load_ph <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (stop_pend) begin
                        state <= DONE;
                    end else if (gap_cnt == '0) begin
                        state   <= LOAD;
                        rd_idx  <= '0;
                        load_ph <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign frames_sent   = frames_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tuser  = 1'b0;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tvalid = tvalid_q;

endmodule

// File: tb/tb_eth_frame_sender.sv
// Scoreboard bench for eth_frame_sender: expected bytes queued at start, matched against observed transfers.
module tb_eth_frame_sender;

    localparam int unsigned MAXF = 2048;
    localparam int unsigned AW   = $clog2(MAXF / 4);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0, srst = 1'b0;
    logic          mem_req = 1'b0, mem_wenable = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [31:0]   mem_wdata = '0, mem_rdata;
    logic          mem_ack;
    logic          start = 1'b0, stop = 1'b0;
    logic [15:0]   frame_len = '0, gap = '0;
    logic [31:0]   frame_count = '0;
    logic          busy;
    logic [63:0]   frames_sent;

    eth_frame_sender_if axis ();

    eth_frame_sender #(
        .C_AXI_WIDTH      (32),
        .C_MAX_FRAME_SIZE (MAXF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .srst        (srst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wenable (mem_wenable),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .start       (start),
        .stop        (stop),
        .frame_len   (frame_len),
        .frame_count (frame_count),
        .gap         (gap),
        .busy        (busy),
        .frames_sent (frames_sent),
        .m_axis      (axis)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         cyc;
    } obs_t;

    obs_t       obs_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] tmpl [MAXF];
    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int busy_fall_cyc = -1;
    logic busy_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        obs_t o;
        if (axis.tvalid === 1'b1 && axis.tready === 1'b1) begin
            o.data = axis.tdata;
            o.last = axis.tlast;
            o.cyc  = cyc;
            obs_q.push_back(o);
        end
        if (busy_d === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
        busy_d = busy;
    end

    // Stimulus helpers (no checking inside)
    task automatic mem_access(input bit we, input int addr, input logic [31:0] wd,
                              output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_wenable = we; mem_addr = AW'(addr); mem_wdata = wd;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (mem_ack !== 1'b1 && lat < 8);
        rd = mem_rdata;
        if (mem_ack !== 1'b1) lat = 99;
        mem_req = 1'b0;
    endtask

    task automatic push_frames(input int len, input int n);
        int l;
        l = (len < 60) ? 60 : len;
        if (l > int'(MAXF)) l = MAXF;
        for (int f = 0; f < n; f++)
            for (int i = 0; i < l; i++)
                exp_q.push_back({(i == l - 1), (i < len) ? tmpl[i] : 8'h00});
    endtask

    task automatic start_burst(input int len, input int cnt, input int g, input bit with_stop,
                               output int st, output bit busy1);
        @(posedge clk); #1;
        frame_len = 16'(len); frame_count = 32'(cnt); gap = 16'(g);
        start = 1'b1; stop = with_stop; st = cyc;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0; busy1 = busy;
    endtask

    task automatic wait_idle(input int maxc, output bit to);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        to = (busy !== 1'b0);
    endtask

    task automatic load_template();
        logic [31:0] rd;
        int lat;
        for (int i = 0; i < 128; i++) tmpl[i] = 8'(i * 3 + 1);
        for (int w = 0; w < 32; w++)
            mem_access(1'b1, w, {tmpl[4*w+3], tmpl[4*w+2], tmpl[4*w+1], tmpl[4*w]}, rd, lat);
    endtask

    // Tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors += 6;
        if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", axis.tvalid); end
        if (axis.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", axis.tlast); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (mem_ack !== 1'b0) begin errors++; $display("FAIL rst_mem_ack: got %b want 0", mem_ack); end
        if (frames_sent !== 64'd0) begin errors++; $display("FAIL rst_frames: got %0d want 0", frames_sent); end
        if (mem_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", mem_rdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_mem_rw();
        logic [31:0] rd;
        int lat;
        mem_access(1'b1, 0, 32'h04030201, rd, lat);
        vectors++;
        if (lat != 1) begin errors++; $display("FAIL mem_wr_ack: got latency %0d want 1", lat); end
        mem_access(1'b0, 0, 32'h0, rd, lat);
        vectors += 2;
        if (lat != 1) begin errors++; $display("FAIL mem_rd_ack: got latency %0d want 1", lat); end
        if (rd !== 32'h04030201) begin errors++; $display("FAIL mem_rdata: got %h want 04030201", rd); end
    endtask

    task automatic test_padding();
        int st, idx, tl_cyc;
        bit b1, to;
        obs_t o;
        logic [8:0] e;
        obs_q.delete(); exp_q.delete();
        axis.tready = 1'b1;
        push_frames(14, 1);
        start_burst(14, 1, 0, 0, st, b1);
        wait_idle(500, to);
        repeat (2) @(posedge clk);
        #1;
        vectors += 4;
        if (b1 !== 1'b1) begin errors++; $display("FAIL pad_busy_t1: got %b want 1", b1); end
        if (to) begin errors++; $display("FAIL pad_timeout: busy still %b", busy); end
        if (obs_q.size() != 60) begin errors++; $display("FAIL pad_count: got %0d want 60", obs_q.size()); end
        if (frames_sent !== 64'd1) begin errors++; $display("FAIL pad_frames: got %0d want 1", frames_sent); end
        if (obs_q.size() > 0) begin
            vectors++;
            if (obs_q[0].cyc != st + 3) begin errors++; $display("FAIL pad_first_lat: got %0d want 3", obs_q[0].cyc - st); end
        end
        idx = 0; tl_cyc = -1000;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL pad_missing: byte %0d never sent", idx); exp_q.delete(); break; end
            o = obs_q.pop_front();
            if ({o.last, o.data} !== e) begin
                errors++; $display("FAIL pad_byte[%0d]: got last=%b data=%h want last=%b data=%h", idx, o.last, o.data, e[8], e[7:0]);
            end
            if (o.last) tl_cyc = o.cyc;
            idx++;
        end
        vectors++;
        if (busy_fall_cyc - tl_cyc != 2) begin errors++; $display("FAIL pad_busy_fall: got %0d cycles after tlast want 2", busy_fall_cyc - tl_cyc); end
    endtask

    task automatic test_back_pressure();
        int st, n, idx;
        bit b1, stall;
        logic [7:0] pd;
        logic pl;
        obs_t o;
        logic [8:0] e;
        obs_q.delete(); exp_q.delete();
        axis.tready = 1'b0;
        push_frames(100, 1);
        start_burst(100, 1, 0, 0, st, b1);
        n = 0; stall = 1'b0; pd = '0; pl = 1'b0;
        while (n < 3000) begin
            @(posedge clk); #1;
            axis.tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (stall) begin
                vectors++;
                if (axis.tvalid !== 1'b1 || axis.tdata !== pd || axis.tlast !== pl) begin
                    errors++; $display("FAIL bp_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", axis.tvalid, axis.tdata, axis.tlast, pd, pl);
                end
            end
            stall = (axis.tvalid === 1'b1) && (axis.tready === 1'b0);
            pd = axis.tdata; pl = axis.tlast;
            n++;
            if (busy === 1'b0) break;
        end
        axis.tready = 1'b1;
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_timeout: busy %b after %0d cycles", busy, n); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL bp_missing: byte %0d never sent", idx); exp_q.delete(); break; end
            o = obs_q.pop_front();
            if ({o.last, o.data} !== e) begin
                errors++; $display("FAIL bp_byte[%0d]: got last=%b data=%h want last=%b data=%h", idx, o.last, o.data, e[8], e[7:0]);
            end
            idx++;
        end
        vectors++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL bp_extra: got %0d extra bytes want 0", obs_q.size()); end
    endtask

    task automatic test_gap_count();
        int st, idx, prev_tl;
        bit b1, to;
        obs_t o;
        logic [8:0] e;
        obs_q.delete(); exp_q.delete();
        axis.tready = 1'b1;
        push_frames(64, 3);
        start_burst(64, 3, 12, 0, st, b1);
        wait_idle(2000, to);
        repeat (2) @(posedge clk);
        #1;
        vectors += 2;
        if (to) begin errors++; $display("FAIL gap_timeout: busy still %b", busy); end
        if (frames_sent !== 64'd3) begin errors++; $display("FAIL gap_frames: got %0d want 3", frames_sent); end
        idx = 0; prev_tl = -1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL gap_missing: byte %0d never sent", idx); exp_q.delete(); break; end
            o = obs_q.pop_front();
            if ({o.last, o.data} !== e) begin
                errors++; $display("FAIL gap_byte[%0d]: got last=%b data=%h want last=%b data=%h", idx, o.last, o.data, e[8], e[7:0]);
            end
            if (idx % 64 == 0 && prev_tl >= 0) begin
                vectors++;
                if (o.cyc - prev_tl - 1 != 14) begin errors++; $display("FAIL gap_idle: got %0d idle cycles want 14", o.cyc - prev_tl - 1); end
            end
            if (o.last) prev_tl = o.cyc;
            idx++;
        end
        vectors++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL gap_extra: got %0d extra bytes want 0", obs_q.size()); end
    endtask

    task automatic test_stop();
        int st, n, idx;
        bit b1, to;
        obs_t o;
        logic [8:0] e;
        obs_q.delete(); exp_q.delete();
        axis.tready = 1'b1;
        push_frames(60, 2);
        start_burst(60, 0, 4, 0, st, b1);
        n = 0;
        while (obs_q.size() < 90 && n < 1000) begin @(posedge clk); #1; n++; end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_idle(1000, to);
        repeat (20) @(posedge clk);
        #1;
        vectors += 2;
        if (to) begin errors++; $display("FAIL stop_timeout: busy still %b", busy); end
        if (frames_sent !== 64'd2) begin errors++; $display("FAIL stop_frames: got %0d want 2", frames_sent); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL stop_missing: byte %0d never sent", idx); exp_q.delete(); break; end
            o = obs_q.pop_front();
            if ({o.last, o.data} !== e) begin
                errors++; $display("FAIL stop_byte[%0d]: got last=%b data=%h want last=%b data=%h", idx, o.last, o.data, e[8], e[7:0]);
            end
            idx++;
        end
        vectors++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL stop_extra: got %0d extra bytes want 0", obs_q.size()); end
    endtask

    task automatic test_start_stop_same();
        int st, idx;
        bit b1, to;
        obs_t o;
        logic [8:0] e;
        obs_q.delete(); exp_q.delete();
        axis.tready = 1'b1;
        push_frames(0, 1);
        start_burst(0, 0, 0, 1, st, b1);
        wait_idle(500, to);
        repeat (10) @(posedge clk);
        #1;
        vectors += 2;
        if (to) begin errors++; $display("FAIL ss_timeout: busy still %b", busy); end
        if (frames_sent !== 64'd1) begin errors++; $display("FAIL ss_frames: got %0d want 1", frames_sent); end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL ss_missing: byte %0d never sent", idx); exp_q.delete(); break; end
            o = obs_q.pop_front();
            if ({o.last, o.data} !== e) begin
                errors++; $display("FAIL ss_byte[%0d]: got last=%b data=%h want last=%b data=%h", idx, o.last, o.data, e[8], e[7:0]);
            end
            idx++;
        end
        vectors++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL ss_extra: got %0d extra bytes want 0", obs_q.size()); end
    endtask

    task automatic test_srst();
        int st, n, lat;
        bit b1;
        logic [31:0] rd, want;
        obs_q.delete(); exp_q.delete();
        axis.tready = 1'b1;
        start_burst(100, 0, 0, 0, st, b1);
        n = 0;
        while (obs_q.size() < 120 && n < 1000) begin @(posedge clk); #1; n++; end
        vectors++;
        if (obs_q.size() < 120) begin errors++; $display("FAIL srst_pre: got %0d bytes want 120", obs_q.size()); end
        srst = 1'b1;
        @(posedge clk); #1;
        vectors += 3;
        if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL srst_tvalid: got %b want 0", axis.tvalid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL srst_busy: got %b want 0", busy); end
        if (frames_sent !== 64'd0) begin errors++; $display("FAIL srst_frames: got %0d want 0", frames_sent); end
        srst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (axis.tvalid !== 1'b0) begin errors++; $display("FAIL srst_idle: got tvalid %b want 0", axis.tvalid); end
        for (int w = 0; w < 4; w++) begin
            mem_access(1'b0, w, 32'h0, rd, lat);
            want = {tmpl[4*w+3], tmpl[4*w+2], tmpl[4*w+1], tmpl[4*w]};
            vectors++;
            if (rd !== want) begin errors++; $display("FAIL srst_tmpl[%0d]: got %h want %h", w, rd, want); end
        end
        obs_q.delete();
    endtask

    initial begin
        axis.tready = 1'b0;
        test_reset();
        test_mem_rw();
        load_template();
        test_padding();
        test_back_pressure();
        test_gap_count();
        test_stop();
        test_start_stop_same();
        test_srst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
